serial_sub_ctrl: RTL and testbench



---
 rtl/serial_sub_ctrl_if.sv | 34 +++
 rtl/serial_sub_ctrl.sv | 111 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_sub_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_sub_ctrl_if                                              |
// | Purpose  : Request/result bundle for the bit-serial subtractor controller. |
// |            The requester drives start/a/b/bin. The controller returns      |
// |            ready/busy, a one-cycle done pulse and the held diff/bout.      |
// | Modports : master - requester side (drives start, a, b, bin)               |
// |            slave  - controller side (drives ready, busy, done, diff, bout) |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  ready, busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output ready, busy, done, diff, bout
    );
endinterface
`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_sub_ctrl                                                 |
// | Purpose  : Bit-serial subtractor. Computes diff = a - b - bin one bit per  |
// |            clock, LSB first, using a single full-subtractor cell and a     |
// |            borrow flop. One operation takes WIDTH+1 cycles.                |
// | Ports    : clk  - rising-edge clock                                        |
// |            rst  - asynchronous active-high reset                           |
// |            bus  - serial_sub_ctrl_if.slave: start/a/b/bin in;              |
// |                   ready/busy/done/diff/bout out                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_sub_ctrl_if.slave   bus
);

    localparam int                 c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic               r_br;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_done;
    logic               r_busy;

    // Full-subtractor cell on the current LSBs and the running borrow
    logic               w_x;
    logic               w_y;
    logic               w_r;
    logic               w_nb;
    logic [WIDTH-1:0]   w_res_next;

    assign w_x        = r_sa[0];
    assign w_y        = r_sb[0];
    assign w_r        = w_x ^ w_y ^ r_br;
    assign w_nb       = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB
    assign w_res_next = {w_r, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // DONE accepts a new request exactly like IDLE so requests
                // can run back-to-back without a bubble cycle.
                c_IDLE, c_DONE: begin
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_RUN;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_RUN: begin
                    r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
                    r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
                    r_res <= w_res_next;
                    r_br  <= w_nb;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_diff  <= w_res_next;
                        r_bout  <= w_nb;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= c_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ~r_busy;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.diff  = r_diff;
    assign bus.bout  = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_sub_ctrl                                              |
// | Purpose  : Scoreboard bench for serial_sub_ctrl at WIDTH=8 (directed       |
// |            vectors) and WIDTH=2 (all operand combinations). Drivers push   |
// |            expected diff/bout and done cycle; monitors pop on done.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_serial_sub_ctrl;

    typedef struct {
        logic [7:0] d;
        logic       bo;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t q8[$];
    exp_t q2[$];
    logic [7:0] last8 = '0;
    logic [1:0] last2 = '0;

    serial_sub_ctrl_if #(.WIDTH(8)) if8 ();
    serial_sub_ctrl_if #(.WIDTH(2)) if2 ();

    serial_sub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_sub_ctrl #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last8 = '0;
        end else begin
            checks++;
            if (if8.ready !== ~if8.busy || (if8.done === 1'b1 && if8.busy === 1'b1)) begin
                errors++;
                $display("FAIL w8_flags ready=%b busy=%b done=%b required ready=~busy and not(done&busy)",
                         if8.ready, if8.busy, if8.done);
            end
            if (if8.busy === 1'b1) begin
                checks++;
                if (if8.diff !== last8) begin
                    errors++;
                    $display("FAIL w8_hold diff=%h required=%h", if8.diff, last8);
                end
            end
            if (if8.done === 1'b1) begin
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL w8_unexpected_done diff=%h bout=%b cyc=%0d required=no done",
                             if8.diff, if8.bout, cyc);
                end else begin
                    e = q8.pop_front();
                    if (if8.diff !== e.d || if8.bout !== e.bo || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL w8_result diff=%h bout=%b cyc=%0d required diff=%h bout=%b cyc=%0d",
                                 if8.diff, if8.bout, cyc, e.d, e.bo, e.cyc);
                    end
                end
                last8 = if8.diff;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last2 = '0;
        end else begin
            checks++;
            if (if2.ready !== ~if2.busy || (if2.done === 1'b1 && if2.busy === 1'b1)) begin
                errors++;
                $display("FAIL w2_flags ready=%b busy=%b done=%b required ready=~busy and not(done&busy)",
                         if2.ready, if2.busy, if2.done);
            end
            if (if2.busy === 1'b1) begin
                checks++;
                if (if2.diff !== last2) begin
                    errors++;
                    $display("FAIL w2_hold diff=%h required=%h", if2.diff, last2);
                end
            end
            if (if2.done === 1'b1) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL w2_unexpected_done diff=%h bout=%b cyc=%0d required=no done",
                             if2.diff, if2.bout, cyc);
                end else begin
                    e = q2.pop_front();
                    if (if2.diff !== e.d[1:0] || if2.bout !== e.bo || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL w2_result diff=%h bout=%b cyc=%0d required diff=%h bout=%b cyc=%0d",
                                 if2.diff, if2.bout, cyc, e.d[1:0], e.bo, e.cyc);
                    end
                end
                last2 = if2.diff;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic wait_ready8();
        int n = 0;
        @(negedge clk);
        while (if8.ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (if8.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL w8_ready_timeout ready=%b required=1", if8.ready);
        end
    endtask

    task automatic wait_ready2();
        int n = 0;
        @(negedge clk);
        while (if2.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (if2.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL w2_ready_timeout ready=%b required=1", if2.ready);
        end
    endtask

    // Accept edge is the next posedge, i.e. cyc+1; done is seen WIDTH edges later
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                          input logic [7:0] ed, input logic eb);
        exp_t e;
        wait_ready8();
        if8.start = 1'b1;
        if8.a     = a;
        if8.b     = b;
        if8.bin   = bi;
        e.d = ed; e.bo = eb; e.cyc = cyc + 1 + 8;
        q8.push_back(e);
        @(negedge clk);
        if8.start = 1'b0;
        if8.a     = ~a;
        if8.b     = ~b;
        if8.bin   = ~bi;
    endtask

    task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic bi);
        exp_t e;
        logic [2:0] full;
        full = {1'b0, a} - {1'b0, b} - {2'b00, bi};
        wait_ready2();
        if2.start = 1'b1;
        if2.a     = a;
        if2.b     = b;
        if2.bin   = bi;
        e.d = {6'd0, full[1:0]}; e.bo = full[2]; e.cyc = cyc + 1 + 2;
        q2.push_back(e);
        @(negedge clk);
        if2.start = 1'b0;
        if2.a     = ~a;
        if2.b     = ~b;
        if2.bin   = ~bi;
    endtask

    task automatic drain();
        int n = 0;
        while ((q8.size() != 0 || q2.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q2.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending8=%0d pending2=%0d required=0", q8.size(), q2.size());
            q8.delete();
            q2.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (if8.ready !== 1'b1 || if8.busy !== 1'b0 || if8.done !== 1'b0 ||
            if8.diff !== 8'h00 || if8.bout !== 1'b0 ||
            if2.ready !== 1'b1 || if2.busy !== 1'b0 || if2.done !== 1'b0 ||
            if2.diff !== 2'b00 || if2.bout !== 1'b0) begin
            errors++;
            $display("FAIL %s r/b/d/diff/bout w8=%b%b%b/%h/%b w2=%b%b%b/%h/%b required 100/0/0",
                     tag, if8.ready, if8.busy, if8.done, if8.diff, if8.bout,
                     if2.ready, if2.busy, if2.done, if2.diff, if2.bout);
        end
    endtask

    initial begin
        int n;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.bin = 1'b0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.bin = 1'b0;
        #2;
        check_reset_outputs("reset_init");
        @(negedge clk);
        rst = 1'b0;

        // Basic arithmetic and borrow boundaries
        issue8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        issue8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        issue8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
        issue8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        drain();

        // Start during RUN is ignored
        issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.bin = 1'b0;
        @(negedge clk);
        if8.start = 1'b0;
        drain();
        repeat (4) @(negedge clk);

        // Asynchronous reset in mid-RUN discards the operation
        issue8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset_midrun");
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        issue8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0);
        drain();

        // Back-to-back with start held high
        wait_ready8();
        if8.start = 1'b1; if8.a = 8'h05; if8.b = 8'h03; if8.bin = 1'b0;
        q8.push_back('{d: 8'h02, bo: 1'b0, cyc: cyc + 9});
        @(negedge clk);
        n = 0;
        while (if8.ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if8.a = 8'h03; if8.b = 8'h05;
        q8.push_back('{d: 8'hFE, bo: 1'b1, cyc: cyc + 9});
        @(negedge clk);
        if8.start = 1'b0;
        drain();

        // WIDTH=2 exhaustive
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int bi = 0; bi < 2; bi++)
                    issue2(a[1:0], b[1:0], bi[0]);
        drain();

        // Idle tail: any spurious done is flagged by the monitors
        repeat (15) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
